// File: rtl/puf_soc_multi_counter_if.sv
// Bundle of control, RO event and result signals for the multi-channel PUF counter.
// The master drives requests and events; the slave (the counter) returns results.
interface puf_soc_multi_counter_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 24
);

  logic                    i_start;
  logic                    i_abort;
  logic                    i_op_mode;
  logic [WIN_W-1:0]        i_win_len;
  logic [NUM_CH-1:0]       i_ch_en;
  logic [NUM_CH-1:0]       i_ro_evt;
  logic                    o_busy;
  logic                    o_valid;
  logic [NUM_CH*CNT_W-1:0] o_cnt;
  logic [NUM_CH-1:0]       o_sat;
  logic [NUM_CH/2-1:0]     o_resp;

  modport master (
    output i_start, i_abort, i_op_mode, i_win_len, i_ch_en, i_ro_evt,
    input  o_busy, o_valid, o_cnt, o_sat, o_resp
  );

  modport slave (
    input  i_start, i_abort, i_op_mode, i_win_len, i_ch_en, i_ro_evt,
    output o_busy, o_valid, o_cnt, o_sat, o_resp
  );

endinterface

// File: rtl/puf_soc_multi_counter.sv
// Multi-channel PUF ring-oscillator counter: counts RO events per channel over a
// programmable window, captures all counts at once and derives one bit per channel pair.
module puf_soc_multi_counter #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  puf_soc_multi_counter_if.slave bus
);

  localparam int               NUM_PAIR = NUM_CH / 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef logic [NUM_CH-1:0][CNT_W-1:0] cnt_arr_t;

  // A pair only votes when both of its oscillators took part in the window.
  function automatic logic [NUM_PAIR-1:0] resp_calc(input cnt_arr_t cnt,
                                                    input logic [NUM_CH-1:0] en);
    logic [NUM_PAIR-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_PAIR; k++) begin
      r[k] = en[2*k] & en[2*k+1] & (cnt[2*k] > cnt[2*k+1]);
    end
    return r;
  endfunction

  state_e              state_q,    state_d;
  logic [WIN_W-1:0]    win_len_q,  win_len_d;
  logic [WIN_W-1:0]    win_cnt_q,  win_cnt_d;
  logic [NUM_CH-1:0]   ch_en_q,    ch_en_d;
  cnt_arr_t            cnt_q,      cnt_d;
  logic [NUM_CH-1:0]   sat_q,      sat_d;
  cnt_arr_t            out_cnt_q,  out_cnt_d;
  logic [NUM_CH-1:0]   out_sat_q,  out_sat_d;
  logic [NUM_PAIR-1:0] out_resp_q, out_resp_d;
  logic                valid_q,    valid_d;
  logic                busy_q,     busy_d;

  // Next-state, window/event counting and capture logic.
  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    win_cnt_d  = win_cnt_q;
    ch_en_d    = ch_en_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    out_cnt_d  = out_cnt_q;
    out_sat_d  = out_sat_q;
    out_resp_d = out_resp_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && (bus.i_win_len != '0)) begin
          state_d   = ST_COUNT;
          win_len_d = bus.i_win_len;
          ch_en_d   = bus.i_ch_en;
          win_cnt_d = '0;
          cnt_d     = '0;
          sat_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COUNT: begin
        if (bus.i_abort) begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          cnt_d     = '0;
          sat_d     = '0;
        end else begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ch_en_q[ch] && bus.i_ro_evt[ch]) begin
              if (cnt_q[ch] == CNT_MAX) begin
                sat_d[ch] = 1'b1;
              end else begin
                cnt_d[ch] = cnt_q[ch] + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end else begin
              cnt_d[ch] = cnt_q[ch];
            end
          end
          win_cnt_d = win_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1};
          if (win_cnt_d == win_len_q) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_COUNT;
          end
        end
      end

      ST_CAPTURE: begin
        if (bus.i_abort) begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          cnt_d     = '0;
          sat_d     = '0;
        end else begin
          out_cnt_d  = cnt_q;
          out_sat_d  = sat_q;
          out_resp_d = resp_calc(cnt_q, ch_en_q);
          valid_d    = 1'b1;
          win_cnt_d  = '0;
          cnt_d      = '0;
          sat_d      = '0;
          // A zero-length re-arm is treated like a zero-length start and ends the run.
          if (bus.i_op_mode && (bus.i_win_len != '0)) begin
            state_d   = ST_COUNT;
            win_len_d = bus.i_win_len;
            ch_en_d   = bus.i_ch_en;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        win_cnt_d = '0;
        cnt_d     = '0;
        sat_d     = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      ch_en_q    <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
      out_cnt_q  <= '0;
      out_sat_q  <= '0;
      out_resp_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_len_q  <= win_len_d;
      win_cnt_q  <= win_cnt_d;
      ch_en_q    <= ch_en_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      out_cnt_q  <= out_cnt_d;
      out_sat_q  <= out_sat_d;
      out_resp_q <= out_resp_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_valid = valid_q;
  assign bus.o_cnt   = out_cnt_q;
  assign bus.o_sat   = out_sat_q;
  assign bus.o_resp  = out_resp_q;

endmodule

// File: doc/puf_soc_multi_counter.md
Name: puf_soc_multi_counter

Overview:
- Multi-channel successor to the single-channel PUF counter.
- Counts synchronised ring-oscillator events on NUM_CH channels over a common, programmable window of clk cycles, then captures all counts at once.
- For each adjacent channel pair, derives one PUF response bit.
- Supports one-shot and continuous measurement modes. Sits between the RO synchroniser array and the PUF response/register interface.

Parameters:
- NUM_CH, 8, number of RO channels; must be even and >= 2.
- CNT_W, 16, per-channel event counter width.
- WIN_W, 24, window-length counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start request; sampled only in IDLE
- i_abort  in  1  abort the measurement in progress
- i_op_mode  in  1  0 = one-shot, 1 = continuous
- i_win_len  in  WIN_W  window length in clk cycles
- i_ch_en  in  NUM_CH  per-channel enable
- i_ro_evt  in  NUM_CH  per-channel event, already synchronised, one-cycle-wide
- o_busy  out  1  high in COUNT and CAPTURE
- o_valid  out  1  one-cycle pulse when new results are on the outputs
- o_cnt  out  NUM_CH*CNT_W  captured counts; channel k occupies bits [k*CNT_W +: CNT_W]
- o_sat  out  NUM_CH  captured per-channel saturation flags
- o_resp  out  NUM_CH/2  response bits; bit k = (cnt[2k] > cnt[2k+1])

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. On rst: state IDLE, all internal counters 0, o_busy/o_valid/o_cnt/o_sat/o_resp = 0.
- FSM states: IDLE, COUNT, CAPTURE.
- IDLE -> COUNT: at edge E0 where i_start = 1 and i_win_len != 0. At E0, the block clears all channel counters and saturation flags, latches i_win_len into W, and latches i_ch_en.
- i_start with i_win_len == 0: ignored; stays IDLE; no o_valid.
- COUNT: events are sampled at edges E1..EW, exactly W cycles.
  - Enabled channel: counter +1 per i_ro_evt.
  - Disabled channel: counter holds 0.
  - Saturation: a counter stops at 2^CNT_W-1. An event arriving at max sets that channel's saturation flag, which stays set for the rest of the window.
  - At EW: state -> CAPTURE.
- CAPTURE (one cycle): events in this cycle are discarded (one dead cycle per window). At edge E(W+1):
  - o_cnt, o_sat, o_resp load.
  - o_valid = 1 for exactly one cycle.
  - Next state is chosen by i_op_mode sampled at this edge: 0 -> IDLE; 1 -> COUNT with counters and flags cleared, W and channel enables re-latched from the inputs.
- Response bits: o_resp[k] = 1 only if count[2k] > count[2k+1] (unsigned compare). A tie gives 0. A pair with either channel disabled gives 0.
- o_valid latency: first pulse is in the cycle after E(W+1), i.e. W+2 edges after the start edge. In continuous mode, pulses repeat every W+1 cycles.
- o_cnt/o_sat/o_resp hold their values between captures.
- i_start while busy: ignored.
- i_op_mode changes: take effect only at a CAPTURE edge.
- i_abort in COUNT or CAPTURE:
  - State -> IDLE at the next edge; no o_valid.
  - Outputs keep their previous capture.
  - Internal counters clear.
  - i_abort has priority over capture.
- i_abort in IDLE: no effect.
- Window counter: WIN_W bits wide; never wraps because it terminates at W.
- rst asserted mid-window: immediate return to IDLE with all outputs 0.

Test Plan:
- One-shot, NUM_CH=8, W=10, ch0 event every cycle, ch1 every 2nd cycle -> single o_valid on the 12th cycle after start; cnt0=10, cnt1=5, o_resp[0]=1, o_busy low afterwards.
- Saturation, CNT_W=4, W=20, ch2 event every cycle -> cnt2=15, o_sat[2]=1; other channels unsaturated.
- Continuous mode, W=5, ch3 event every cycle -> o_valid every 6 cycles, cnt3=5 each time. Drop i_op_mode -> exactly one more o_valid, then IDLE.
- Abort at cycle 3 of a W=10 window -> no o_valid, outputs unchanged from the prior capture, o_busy low next cycle. A new start then completes normally.
- Tie and disable: cnt4=cnt5=7 -> o_resp[2]=0. i_ch_en[6]=0 with events on ch6 -> cnt6=0, o_resp[3]=0.
- i_win_len=0 with i_start -> remains IDLE, no o_valid. Assert rst mid-COUNT -> all outputs 0 immediately.
